// File: rtl/crypto_block_sequencer_pkg.sv
// Shared crypto definitions: block geometry defaults and the sequencer state set.
// The upstream p_c register bank sizes itself from the same defaults.
package crypto_block_sequencer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NWORDS = 4;
  localparam int BLK_W      = DEF_DATA_W * DEF_NWORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } seq_state_e;

endpackage

// File: rtl/crypto_block_sequencer_if.sv
// Block handshake to and from the cipher core.
// master = sequencer side (offers a block, receives the result),
// slave  = core side.
interface crypto_block_sequencer_if #(
  parameter int W = crypto_block_sequencer_pkg::BLK_W
);

  logic         core_valid_o;
  logic [W-1:0] core_data_o;
  logic         core_ready_i;
  logic         core_res_valid_i;
  logic [W-1:0] core_res_i;

  modport master (
    output core_valid_o,
    output core_data_o,
    input  core_ready_i,
    input  core_res_valid_i,
    input  core_res_i
  );

  modport slave (
    input  core_valid_o,
    input  core_data_o,
    output core_ready_i,
    output core_res_valid_i,
    output core_res_i
  );

endinterface

// File: rtl/crypto_block_sequencer.sv
// Snapshots the p_c bank on start, hands the block to the cipher core,
// waits (bounded) for the result and holds it for one consumer read.
// Plaintext and result copies are zeroed as soon as they are consumed.
module crypto_block_sequencer
  import crypto_block_sequencer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NWORDS  = DEF_NWORDS,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [DATA_W-1:0]         p_c_i [0:NWORDS-1],
  crypto_block_sequencer_if.master  cif,
  output logic                      ct_valid_o,
  output logic                      ct_rdy_o,
  output logic [DATA_W*NWORDS-1:0]  ct_o,
  input  logic                      ct_ack_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int BLOCK_W = DATA_W * NWORDS;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  seq_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               ct_valid_q, ct_valid_d;
  logic               err_q, err_d;
  logic [BLOCK_W-1:0] blk_packed;

  // Word i of the bank lands in bits [DATA_W*i +: DATA_W] of the block.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_pack
    assign blk_packed[DATA_W*gi +: DATA_W] = p_c_i[gi];
  end

  // State and data registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      ct_q       <= '0;
      timer_q    <= '0;
      ct_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      ct_q       <= ct_d;
      timer_q    <= timer_d;
      ct_valid_q <= ct_valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; inputs not relevant to the current state are ignored.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    ct_d       = ct_q;
    timer_d    = timer_q;
    ct_valid_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          blk_d   = blk_packed;
          err_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cif.core_ready_i) begin
          blk_d   = '0;          // core owns the plaintext now
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the timeout cycle still wins.
        if (cif.core_res_valid_i) begin
          ct_d       = cif.core_res_i;
          ct_valid_d = 1'b1;
          timer_d    = '0;
          state_d    = HOLD;
        end else if (timer_q == TMAX) begin
          ct_d       = '0;
          err_d      = 1'b1;
          ct_valid_d = 1'b1;
          timer_d    = '0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (ct_ack_i) begin
          ct_d    = '0;          // result read once, then scrubbed
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  assign cif.core_valid_o = (state_q == SEND);
  assign cif.core_data_o  = (state_q == SEND) ? blk_q : '0;
  assign ct_rdy_o         = (state_q == HOLD);
  assign ct_o             = (state_q == HOLD) ? ct_q : '0;
  assign ct_valid_o       = ct_valid_q;
  assign busy_o           = (state_q != IDLE);
  assign err_o            = err_q;

endmodule

// File: tb/tb_crypto_block_sequencer.sv
// Scoreboard bench: each accepted start pushes the expected outcome,
// the monitor pops it on every ct_valid_o pulse.
module tb_crypto_block_sequencer;

  logic         clk_i;
  logic         rst_ni;
  logic         start_i;
  logic [31:0]  p_c_i [0:3];
  logic         ct_valid_o;
  logic         ct_rdy_o;
  logic [127:0] ct_o;
  logic         ct_ack_i;
  logic         busy_o;
  logic         err_o;

  crypto_block_sequencer_if #(.W(128)) cif ();

  crypto_block_sequencer #(
    .DATA_W (32),
    .NWORDS (4),
    .TIMEOUT(4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .p_c_i     (p_c_i),
    .cif       (cif),
    .ct_valid_o(ct_valid_o),
    .ct_rdy_o  (ct_rdy_o),
    .ct_o      (ct_o),
    .ct_ack_i  (ct_ack_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  typedef struct {
    logic [127:0] ct;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   n_starts = 0;
  logic [127:0] captured;
  logic [127:0] res_val;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] pack_bank();
    return {p_c_i[3], p_c_i[2], p_c_i[1], p_c_i[0]};
  endfunction

  task automatic push_exp(input logic [127:0] ct, input logic err);
    exp_t e;
    e.ct  = ct;
    e.err = err;
    exp_q.push_back(e);
    n_starts++;
  endtask

  // Pops the scoreboard on every completion pulse and prints one line per transaction.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (rst_ni && ct_valid_o) begin
      pulses++;
      $display("txn %0d: ct_o=%h err_o=%0b ct_rdy_o=%0b", pulses, ct_o, err_o, ct_rdy_o);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pulse", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_ct", ct_o, e.ct);
        chk("sb_err", 128'(err_o), 128'(e.err));
        chk("sb_rdy", 128'(ct_rdy_o), 128'(!e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    ct_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) p_c_i[i] = '0;
    cif.core_ready_i     = 1'b0;
    cif.core_res_valid_i = 1'b0;
    cif.core_res_i       = '0;
    step();
    step();
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_core_valid", 128'(cif.core_valid_o), 128'(0));
    chk("rst_core_data", cif.core_data_o, 128'(0));
    chk("rst_ct_rdy", 128'(ct_rdy_o), 128'(0));
    chk("rst_ct_o", ct_o, 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    rst_ni = 1'b1;
    step();

    // Basic flow
    p_c_i[0] = 32'h1; p_c_i[1] = 32'h2; p_c_i[2] = 32'h3; p_c_i[3] = 32'h4;
    cif.core_ready_i = 1'b1;
    start_i = 1'b1;
    push_exp({4{32'hA5A5A5A5}}, 1'b0);
    step();
    start_i = 1'b0;
    chk("basic_core_valid", 128'(cif.core_valid_o), 128'(1));
    chk("basic_core_data", cif.core_data_o, 128'h00000004_00000003_00000002_00000001);
    chk("basic_busy", 128'(busy_o), 128'(1));
    step();
    cif.core_ready_i = 1'b0;
    chk("basic_wait_data", cif.core_data_o, 128'(0));
    chk("basic_blk_zero", dut.blk_q, 128'(0));
    step();
    step();
    cif.core_res_valid_i = 1'b1;
    cif.core_res_i = {4{32'hA5A5A5A5}};
    step();
    cif.core_res_valid_i = 1'b0;
    cif.core_res_i = '0;
    chk("basic_ct_rdy", 128'(ct_rdy_o), 128'(1));
    chk("basic_ct_o", ct_o, {4{32'hA5A5A5A5}});
    start_i = 1'b1;               // ignored in HOLD
    step();
    start_i = 1'b0;
    chk("basic_single_pulse", 128'(ct_valid_o), 128'(0));
    chk("basic_hold_stays", 128'(ct_rdy_o), 128'(1));
    ct_ack_i = 1'b1;
    step();
    ct_ack_i = 1'b0;
    chk("basic_ack_rdy", 128'(ct_rdy_o), 128'(0));
    chk("basic_ack_ct", ct_o, 128'(0));
    chk("basic_ack_idle", 128'(busy_o), 128'(0));

    // Backpressure with the bank changing under SEND
    for (int i = 0; i < 4; i++) p_c_i[i] = $urandom;
    captured = pack_bank();
    start_i = 1'b1;
    push_exp(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    step();
    for (int i = 0; i < 4; i++) p_c_i[i] = ~p_c_i[i];
    for (int c = 0; c < 5; c++) begin
      start_i = (c == 2);         // ignored in SEND
      chk("bp_core_valid", 128'(cif.core_valid_o), 128'(1));
      chk("bp_core_data", cif.core_data_o, captured);
      step();
    end
    start_i = 1'b0;
    cif.core_ready_i = 1'b1;
    step();
    cif.core_ready_i = 1'b0;
    chk("bp_post_data", cif.core_data_o, 128'(0));
    chk("bp_blk_zero", dut.blk_q, 128'(0));
    ct_ack_i = 1'b1;              // ignored in WAIT
    start_i = 1'b1;               // ignored in WAIT
    step();
    ct_ack_i = 1'b0;
    start_i = 1'b0;
    chk("bp_wait_busy", 128'(busy_o), 128'(1));
    chk("bp_wait_no_rdy", 128'(ct_rdy_o), 128'(0));
    cif.core_res_valid_i = 1'b1;
    cif.core_res_i = 128'h0123456789ABCDEF_FEDCBA9876543210;
    step();
    cif.core_res_valid_i = 1'b0;
    chk("bp_ct_o", ct_o, 128'h0123456789ABCDEF_FEDCBA9876543210);
    ct_ack_i = 1'b1;
    step();
    ct_ack_i = 1'b0;
    chk("bp_idle", 128'(busy_o), 128'(0));

    // Timeout with TIMEOUT=4
    cif.core_ready_i = 1'b1;
    start_i = 1'b1;
    push_exp(128'(0), 1'b1);
    step();
    start_i = 1'b0;
    step();                       // WAIT entry edge
    cif.core_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("to_busy", 128'(busy_o), 128'(1));
      chk("to_no_rdy", 128'(ct_rdy_o), 128'(0));
      step();
    end
    chk("to_idle", 128'(busy_o), 128'(0));
    chk("to_err", 128'(err_o), 128'(1));
    chk("to_ct_o", ct_o, 128'(0));
    cif.core_res_valid_i = 1'b1;  // stray result in IDLE
    cif.core_res_i = {4{32'hDEADBEEF}};
    step();
    cif.core_res_valid_i = 1'b0;
    cif.core_res_i = '0;
    chk("stray_idle", 128'(busy_o), 128'(0));
    chk("stray_err_kept", 128'(err_o), 128'(1));

    // Next start clears err; result lands on the timeout cycle
    res_val = {$urandom, $urandom, $urandom, $urandom};
    cif.core_ready_i = 1'b1;
    start_i = 1'b1;
    push_exp(res_val, 1'b0);
    step();
    start_i = 1'b0;
    chk("coll_err_clr", 128'(err_o), 128'(0));
    step();                       // WAIT entry edge
    cif.core_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("coll_still_wait", 128'(busy_o), 128'(1));
    cif.core_res_valid_i = 1'b1;
    cif.core_res_i = res_val;
    step();
    cif.core_res_valid_i = 1'b0;
    cif.core_res_i = '0;
    chk("coll_hold", 128'(ct_rdy_o), 128'(1));
    chk("coll_err", 128'(err_o), 128'(0));
    ct_ack_i = 1'b1;
    step();
    ct_ack_i = 1'b0;

    // Asynchronous reset while holding a result
    res_val = {4{32'h5A5A_0F0F}};
    cif.core_ready_i = 1'b1;
    start_i = 1'b1;
    push_exp(res_val, 1'b0);
    step();
    start_i = 1'b0;
    step();
    cif.core_ready_i = 1'b0;
    cif.core_res_valid_i = 1'b1;
    cif.core_res_i = res_val;
    step();
    cif.core_res_valid_i = 1'b0;
    chk("rsth_pre_rdy", 128'(ct_rdy_o), 128'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rsth_ct_o", ct_o, 128'(0));
    chk("rsth_rdy", 128'(ct_rdy_o), 128'(0));
    chk("rsth_busy", 128'(busy_o), 128'(0));
    chk("rsth_err", 128'(err_o), 128'(0));
    step();
    rst_ni = 1'b1;
    step();
    chk("rsth_idle", 128'(busy_o), 128'(0));
    res_val = {$urandom, $urandom, $urandom, $urandom};
    p_c_i[0] = 32'hCAFE0000; p_c_i[1] = 32'hCAFE0001; p_c_i[2] = 32'hCAFE0002; p_c_i[3] = 32'hCAFE0003;
    cif.core_ready_i = 1'b1;
    start_i = 1'b1;
    push_exp(res_val, 1'b0);
    step();
    start_i = 1'b0;
    chk("fresh_core_data", cif.core_data_o, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
    step();
    cif.core_ready_i = 1'b0;
    cif.core_res_valid_i = 1'b1;
    cif.core_res_i = res_val;
    step();
    cif.core_res_valid_i = 1'b0;
    chk("fresh_ct_o", ct_o, res_val);
    ct_ack_i = 1'b1;
    step();
    ct_ack_i = 1'b0;
    step();

    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    chk("pulse_count", 128'(pulses), 128'(n_starts));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crypto_block_sequencer.md
# crypto_block_sequencer

Downstream stage of the software-written plaintext/ciphertext register bank (`p_c[0:3]`). On a start command it snapshots the 128-bit block and hands it to the cipher core over a valid/ready handshake. It then waits for the core's result and holds that result for a single consumer read. It returns the one-cycle `ct_valid` pulse that clears the upstream bank, and zeroizes every internal copy of sensitive data as soon as it is no longer needed.

## Interface
Parameters:
- `DATA_W`, 32, width of one `p_c` word
- `NWORDS`, 4, number of words per block; `BLK_W = DATA_W*NWORDS` (128)
- `TIMEOUT`, 255, maximum WAIT cycles before abort; minimum 1, counter width `$clog2(TIMEOUT+1)`

Ports:
- `clk_i`  in  1  clock; one clock domain
- `rst_ni`  in  1  asynchronous, active-low reset
- `start_i`  in  1  start request; sampled only in IDLE
- `p_c_i[0:NWORDS-1]`  in  DATA_W each  upstream register bank
- `core_valid_o`  out  1  block offered to the core
- `core_data_o`  out  BLK_W  block to the core; 0 when `core_valid_o`=0
- `core_ready_i`  in  1  core accepts the block
- `core_res_valid_i`  in  1  core result strobe
- `core_res_i`  in  BLK_W  core result
- `ct_valid_o`  out  1  one-cycle pulse; clears the upstream bank
- `ct_rdy_o`  out  1  result held and readable
- `ct_o`  out  BLK_W  result; 0 when `ct_rdy_o`=0
- `ct_ack_i`  in  1  consumer has read the result
- `busy_o`  out  1  state is not IDLE
- `err_o`  out  1  timeout flag; sticky until the next accepted start

## Operation
- Block packing: `p_c_i[i]` maps to `blk[DATA_W*i +: DATA_W]`, so `p_c_i[0]` is bits 31:0.
- States:
  - **IDLE**
    - `start_i`=1: capture the packed block into `blk_q`, clear `err_o`, go to SEND.
    - Otherwise: stay in IDLE.
  - **SEND**
    - `core_valid_o`=1 and `core_data_o`=`blk_q`.
    - Hold both stable until `core_ready_i`=1.
    - On handshake: set `blk_q` to 0, clear the timer, go to WAIT.
  - **WAIT**
    - The timer increments every cycle.
    - `core_res_valid_i`=1: `ct_q`<=`core_res_i`, pulse `ct_valid_o`, go to HOLD.
    - Timer reaches `TIMEOUT` with no result: set `err_o`=1, pulse `ct_valid_o`, leave `ct_q`=0, go to IDLE.
    - If both conditions hold in the same cycle, the result wins.
  - **HOLD**
    - `ct_rdy_o`=1 and `ct_o`=`ct_q`.
    - `ct_ack_i`=1: set `ct_q` to 0, go to IDLE.
- `start_i` is ignored outside IDLE: no queuing, no error.
- `core_res_valid_i` is ignored outside WAIT.
- `ct_ack_i` is ignored outside HOLD.
- Reset (asynchronous, any state):
  - state goes to IDLE
  - `blk_q`, `ct_q`, timer and every output go to 0
  - an in-flight core transaction is abandoned

## Timing
- All outputs are registered or decoded directly from state and registers; there are no combinational input-to-output paths.
- Latency, with `start_i` sampled at edge k:
  - `core_valid_o` is high in cycle k+1.
  - If `core_ready_i` is already high in that cycle, WAIT begins at k+2.
  - If the result is sampled at edge m, `ct_valid_o` and `ct_rdy_o` are high in cycle m+1.
- `ct_valid_o` is high for exactly one cycle per accepted start, whether the block completes or times out.
- An ack sampled at edge a gives `ct_rdy_o`=0 and `ct_o`=0 in cycle a+1; a new start can be sampled at edge a+1.
- Timeout: the timer starts at 0 on the WAIT entry edge. With no result, the block is back in IDLE with `err_o`=1 exactly `TIMEOUT`+1 cycles after that entry edge.

## Structure
- Shared crypto package holds:
  - the state enum `seq_state_e` (IDLE, SEND, WAIT, HOLD)
  - `BLK_W`
  - the default `NWORDS`/`DATA_W`, which the upstream bank also uses
- Single module; no sub-module. Timer and packing stay inline.

## Test plan
- Basic flow:
  - Stimulus: `p_c_i`={32'h1,32'h2,32'h3,32'h4}, start; core ready immediately; result 128'hA5..A5 after 3 cycles.
  - Response: `core_data_o`=128'h00000004_00000003_00000002_00000001; `ct_valid_o` pulses once; `ct_o`=A5..A5 while `ct_rdy_o`; ack gives `ct_o`=0 the next cycle.
- Backpressure:
  - Stimulus: hold `core_ready_i`=0 for 5 cycles; change `p_c_i` mid-SEND.
  - Response: `core_data_o` stays at the captured value; `blk_q` reads 0 after the handshake.
- Timeout:
  - Stimulus: `TIMEOUT`=4, no result.
  - Response: `err_o`=1 and one `ct_valid_o` pulse; IDLE 5 cycles after WAIT entry; `ct_rdy_o` never high; the next start clears `err_o`.
- Ignored inputs:
  - Stimulus: `start_i` during SEND/WAIT/HOLD; a stray `core_res_valid_i` in IDLE; `ct_ack_i` in WAIT.
  - Response: no state change and no extra pulse.
- Reset mid-HOLD:
  - Stimulus: assert `rst_ni`=0 asynchronously between edges.
  - Response: `ct_o`, `ct_rdy_o`, `busy_o` and `err_o` go to 0 immediately; after release the block returns to IDLE and a fresh start completes normally.
- Result/timeout collision:
  - Stimulus: result arrives on the timeout cycle.
  - Response: goes to HOLD with `err_o`=0.
